// File: rtl/decode_div_div_31s_15ns_16_seq_if.sv
// Request/result bundle for the ADPCM decode divider.
// The master issues start with operands and the slave returns results flagged by done.
interface decode_div_div_31s_15ns_16_seq_if;
  logic        start;
  logic [30:0] din0;
  logic [14:0] din1;
  logic        ready;
  logic        done;
  logic [15:0] dout;
  logic [15:0] rem;
  logic        ovf;
  logic        dbz;

  modport master (
    output start, din0, din1,
    input  ready, done, dout, rem, ovf, dbz
  );

  modport slave (
    input  start, din0, din1,
    output ready, done, dout, rem, ovf, dbz
  );
endinterface

// File: rtl/decode_div_div_31s_15ns_16_seq.sv
// Fixed-latency radix-2 restoring divider: 31-bit signed / 15-bit unsigned,
// saturated 16-bit signed quotient and sign-following 16-bit remainder.
//
// state  | meaning
// IDLE   | ready for start; results held
// CALC   | one quotient bit per enabled edge, count 30 down to 0
// FIX    | sign-correct, saturate, register results, pulse done
module decode_div_div_31s_15ns_16_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 31,
  parameter int din1_WIDTH = 15,
  parameter int dout_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  decode_div_div_31s_15ns_16_seq_if.slave bus
);

  generate
    if (ID < 0 || din0_WIDTH != 31 || din1_WIDTH != 15 || dout_WIDTH != 16) begin : g_bad_cfg
      $error("decode_div_div_31s_15ns_16_seq: unsupported configuration");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt_r;
  logic        sign_r;
  logic [30:0] work_r;   // dividend shifts out the top while quotient bits enter the bottom
  logic [14:0] dsor_r;
  logic [15:0] rem_r;
  logic        done_r;
  logic [15:0] dout_r;
  logic [15:0] rem_out_r;
  logic        ovf_r;
  logic        dbz_r;

  logic [16:0] rem_sh;
  logic        rem_ge;

  assign rem_sh = {rem_r, work_r[30]};
  assign rem_ge = (rem_sh >= {2'b00, dsor_r});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt_r     <= '0;
      sign_r    <= 1'b0;
      work_r    <= '0;
      dsor_r    <= '0;
      rem_r     <= '0;
      done_r    <= 1'b0;
      dout_r    <= '0;
      rem_out_r <= '0;
      ovf_r     <= 1'b0;
      dbz_r     <= 1'b0;
    end else if (ce) begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            sign_r <= bus.din0[30];
            work_r <= bus.din0[30] ? 31'(-bus.din0) : bus.din0;
            dsor_r <= bus.din1;
            rem_r  <= '0;
            cnt_r  <= 5'd30;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          rem_r  <= rem_ge ? 16'(rem_sh - {2'b00, dsor_r}) : rem_sh[15:0];
          work_r <= {work_r[29:0], rem_ge};
          if (cnt_r == 5'd0) state <= S_FIX;
          else               cnt_r <= cnt_r - 5'd1;
        end
        S_FIX: begin
          done_r <= 1'b1;
          state  <= S_IDLE;
          if (dsor_r == 15'd0) begin
            dbz_r     <= 1'b1;
            ovf_r     <= 1'b0;
            rem_out_r <= '0;
            dout_r    <= sign_r ? 16'h8000 : 16'h7FFF;
          end else begin
            dbz_r     <= 1'b0;
            rem_out_r <= sign_r ? 16'(-rem_r) : rem_r;
            // Negative side reaches one further: -32768 is representable
            if (!sign_r && work_r > 31'd32767) begin
              dout_r <= 16'h7FFF;
              ovf_r  <= 1'b1;
            end else if (sign_r && work_r > 31'd32768) begin
              dout_r <= 16'h8000;
              ovf_r  <= 1'b1;
            end else begin
              dout_r <= sign_r ? 16'(-work_r[15:0]) : work_r[15:0];
              ovf_r  <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready = (state == S_IDLE);
  assign bus.done  = done_r;
  assign bus.dout  = dout_r;
  assign bus.rem   = rem_out_r;
  assign bus.ovf   = ovf_r;
  assign bus.dbz   = dbz_r;

endmodule

// File: doc/decode_div_div_31s_15ns_16_seq.md
# decode_div_div_31s_15ns_16_seq

Sequential signed-by-unsigned divider for the ADPCM decode path, the inverse of the encoder's pipelined 16s×15ns→31 multiplier. It divides a 31-bit signed dividend by a 15-bit unsigned divisor and returns a saturated 16-bit signed quotient and a 16-bit signed remainder. It uses a radix-2 restoring iteration with fixed latency, so the HLS schedule can treat it as a 32-cycle operator.

## Interface
- `ID`, 1: instance identifier; no functional effect.
- `din0_WIDTH`, 31: dividend width. Only 31 is supported.
- `din1_WIDTH`, 15: divisor width. Only 15 is supported.
- `dout_WIDTH`, 16: quotient and remainder width. Only 16 is supported.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ce` in 1: clock enable. When low, all state, counters and outputs hold.
- `start` in 1: request. Sampled only when `ce`=1 and `ready`=1.
- `din0` in 31: signed dividend.
- `din1` in 15: unsigned divisor.
- `ready` out 1: high in IDLE; the block can accept `start`.
- `done` out 1: one-cycle pulse; results are valid.
- `dout` out 16: signed quotient, truncated toward zero, then saturated.
- `rem` out 16: signed remainder; its sign follows the dividend.
- `ovf` out 1: quotient was saturated. Valid with `done`.
- `dbz` out 1: divisor was zero. Valid with `done`.

## Operation
- States are IDLE, CALC and FIX.
- **IDLE, `start`=1 (with `ce`=1):**
  - Latch the dividend sign `s`.
  - Latch the magnitude |din0| as 31-bit unsigned; −2^30 gives 2^30.
  - Latch `din1`, clear the partial remainder, set the count to 30, go to CALC.
- **CALC (one bit per enabled edge, MSB first):**
  - Shift the remainder left and bring in the next dividend bit.
  - If remainder ≥ divisor, subtract the divisor and set the quotient bit to 1.
  - The remainder register is 16 bits unsigned, enough to hold 2×divisor.
  - After the count-0 iteration, go to FIX.
- **FIX (register all results, go to IDLE):**
  - Let Q be the 31-bit quotient magnitude.
  - If the divisor is 0: `dbz`=1, `dout`=32767 if `s`=0 else −32768, `rem`=0, `ovf`=0.
  - Else if `s`=0 and Q>32767: `dout`=32767, `ovf`=1.
  - Else if `s`=1 and Q>32768: `dout`=−32768, `ovf`=1.
  - Otherwise `dout` = Q if `s`=0, else −Q.
  - For any nonzero divisor, `rem` = ±R using sign `s`, from the unsaturated division, so |rem| < divisor.
  - In FIX, `done` is driven to 1 for exactly one enabled cycle.
- `start` while not IDLE is ignored. There is no queueing.
- A divide by zero runs the full iteration anyway; latency is always fixed.
- `dout`, `rem`, `ovf` and `dbz` hold their values until the next FIX.
- **Reset:**
  - `reset`=0 forces IDLE, with `ready`=1 and `done`=0.
  - It also forces `dout`=0, `rem`=0, `ovf`=0, `dbz`=0 and clears all internal registers.
  - A reset mid-operation discards the operation and produces no `done`.

## Timing
- The enabled edge that accepts `start` is edge k.
- There are 31 CALC edges (k+1 … k+31) and one FIX edge (k+32).
- `done`=1 and results are valid during the cycle after edge k+32. Latency is 32 enabled cycles.
- `ready` falls after edge k and rises after edge k+32, together with `done`.
- Back-to-back operation: `start` may be asserted in the cycle where `done`=1. That cycle is edge k′ = k+33, for a throughput of one operation per 33 cycles.
- Each `ce`=0 cycle stretches the latency by one cycle. While `ce`=0, `done` holds its level; it is not re-pulsed.
- `din0` and `din1` need only be valid at the accepting edge.

## Test plan
- **Basic division:** `din0`=1000000, `din1`=1000, `start` at edge k -> `done` after edge k+32; `dout`=1000, `rem`=0, `ovf`=0, `dbz`=0.
- **Signed truncation:** `din0`=−7, `din1`=2 -> `dout`=−3, `rem`=−1. Then `din0`=7, `din1`=2 -> `dout`=3, `rem`=1, issued back-to-back in the `done` cycle, with the second `done` 33 cycles after the first.
- **Saturation:**
  - `din0`=0x3FFFFFFF, `din1`=1 -> `dout`=32767, `ovf`=1, `rem`=0.
  - `din0`=−32768, `din1`=1 -> `dout`=−32768, `ovf`=0.
  - `din0`=−32769, `din1`=1 -> `dout`=−32768, `ovf`=1.
- **Divide by zero:** `din0`=−5, `din1`=0 -> `dout`=−32768, `rem`=0, `dbz`=1, latency still 32.
- **Clock enable and busy:** `ce` low for 5 cycles mid-CALC -> `done` after 37 cycles. A `start` with different operands during CALC is ignored, and the results match the first operands.
- **Reset mid-operation:** `reset` low at CALC count 15 -> immediately `ready`=1, `done`=0, `dout`=0, `rem`=0. No `done` follows. A new `start` after reset completes normally in 32 cycles.
